// File: rtl/riscv_instr_class_counter.sv
// Purpose : retire-side instruction-mix profiler: 8 class counters (+ optional compressed counter) with a snapshot bank.
// Latency : retire at edge t is counted in the live bank at edge t+1 (visible t+2); snapshot/read respond one cycle later.
// Backpres: none; one retire per cycle is absorbed every cycle, the block never stalls its source.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   retire_valid_i/instr_i   retiring instruction (decompressed 32-bit word)
//   retire_compr_i           retiring instruction was originally 16-bit
//   clear_i                  zero live counters and overflow flags
//   snap_req_i/snap_done_o   copy live bank to shadow bank / pulse when done
//   rd_req_i/rd_sel_i        read shadow entry rd_sel_i (0..8)
//   rd_valid_o/rd_data_o     read response, data holds when not valid
//   ovf_o                    sticky per-counter overflow flags of the live bank
//
// Build option: define RISCV_ICC_COMPRESSED_EN to add counter 8 (compressed retires).

module riscv_instr_class_counter #(
   parameter int CNT_WIDTH = 32,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 retire_valid_i,
   input  logic [31:0]          retire_instr_i,
   input  logic                 retire_compr_i,
   input  logic                 clear_i,
   input  logic                 snap_req_i,
   output logic                 snap_done_o,
   input  logic                 rd_req_i,
   input  logic [3:0]           rd_sel_i,
   output logic                 rd_valid_o,
   output logic [CNT_WIDTH-1:0] rd_data_o,
   output logic [8:0]           ovf_o
);

`ifdef RISCV_ICC_COMPRESSED_EN
   localparam int NCNT = 9;
`else
   localparam int NCNT = 8;
`endif

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Opcodes as used by the core's tracer (base ISA plus PULP extensions)
   localparam logic [6:0] OPC_LOAD       = 7'h03;
   localparam logic [6:0] OPC_LOAD_FP    = 7'h07;
   localparam logic [6:0] OPC_LOAD_POST  = 7'h0b;
   localparam logic [6:0] OPC_FENCE      = 7'h0f;
   localparam logic [6:0] OPC_OPIMM      = 7'h13;
   localparam logic [6:0] OPC_AUIPC      = 7'h17;
   localparam logic [6:0] OPC_STORE      = 7'h23;
   localparam logic [6:0] OPC_STORE_FP   = 7'h27;
   localparam logic [6:0] OPC_STORE_POST = 7'h2b;
   localparam logic [6:0] OPC_OP         = 7'h33;
   localparam logic [6:0] OPC_LUI        = 7'h37;
   localparam logic [6:0] OPC_FMADD      = 7'h43;
   localparam logic [6:0] OPC_FMSUB      = 7'h47;
   localparam logic [6:0] OPC_FNMSUB     = 7'h4b;
   localparam logic [6:0] OPC_FNMADD     = 7'h4f;
   localparam logic [6:0] OPC_OP_FP      = 7'h53;
   localparam logic [6:0] OPC_PULP_OP    = 7'h5b;
   localparam logic [6:0] OPC_BRANCH     = 7'h63;
   localparam logic [6:0] OPC_JALR       = 7'h67;
   localparam logic [6:0] OPC_JAL        = 7'h6f;
   localparam logic [6:0] OPC_SYSTEM     = 7'h73;

   typedef struct packed {
      logic       vld;
      logic [7:0] cls;   // one-hot class of the retired word
   } s1_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [2:0] cls_idx;
   logic       unused_instr;

   assign opcode       = retire_instr_i[6:0];
   assign funct3       = retire_instr_i[14:12];
   assign funct7       = retire_instr_i[31:25];
   assign unused_instr = ^{retire_instr_i[24:15], retire_instr_i[11:7]};

   // Classification: mul/div patterns are carved out of OP before it falls into ALU
   always_comb begin
      cls_idx = 3'd7;
      case (opcode)
         OPC_OP:                           cls_idx = (funct7 == 7'b0000001 || funct7 == 7'b0100001) ? 3'd4 : 3'd0;
         OPC_OPIMM, OPC_LUI, OPC_AUIPC:    cls_idx = 3'd0;
         OPC_JAL, OPC_JALR, OPC_BRANCH:    cls_idx = 3'd1;
         OPC_LOAD, OPC_LOAD_POST:          cls_idx = 3'd2;
         OPC_STORE, OPC_STORE_POST:        cls_idx = 3'd3;
         // funct3 in {000,001,100,101} is exactly funct3[1] == 0
         OPC_PULP_OP:                      cls_idx = funct3[1] ? 3'd7 : 3'd4;
         OPC_SYSTEM, OPC_FENCE:            cls_idx = 3'd5;
         OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD,
         OPC_LOAD_FP, OPC_STORE_FP:        cls_idx = 3'd6;
         default:                          cls_idx = 3'd7;
      endcase
   end

   // ---------------- S1: register the decoded retire ----------------
   s1_t             s1_q;
   logic [NCNT-1:0] inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else begin
         s1_q.vld <= retire_valid_i;
         s1_q.cls <= 8'b1 << cls_idx;
      end
   end

`ifdef RISCV_ICC_COMPRESSED_EN
   logic s1_compr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_compr_q <= 1'b0;
      end else begin
         s1_compr_q <= retire_compr_i;
      end
   end

   assign inc = {s1_q.vld & s1_compr_q, s1_q.vld ? s1_q.cls : 8'h00};
`else
   logic unused_compr;

   assign unused_compr = retire_compr_i;
   assign inc          = s1_q.vld ? s1_q.cls : 8'h00;
`endif

   // ---------------- S2: live bank ----------------
   logic [CNT_WIDTH-1:0] live_q   [NCNT];
   logic [CNT_WIDTH-1:0] live_nxt [NCNT];
   logic [CNT_WIDTH-1:0] shadow_q [NCNT];
   logic [NCNT-1:0]      ovf_q;
   logic [NCNT-1:0]      ovf_hit;

   always_comb begin
      for (int i = 0; i < NCNT; i++) begin
         live_nxt[i] = live_q[i];
         ovf_hit[i]  = 1'b0;
         if (inc[i]) begin
            if (&live_q[i]) begin
               ovf_hit[i]  = 1'b1;
               live_nxt[i] = SATURATE ? live_q[i] : '0;
            end else begin
               live_nxt[i] = live_q[i] + CNT_ONE;
            end
         end
      end
   end

   // Clear wins over the increment landing on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCNT; i++) live_q[i] <= '0;
         ovf_q <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < NCNT; i++) live_q[i] <= '0;
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NCNT; i++) live_q[i] <= live_nxt[i];
         ovf_q <= ovf_q | ovf_hit;
      end
   end

   // Snapshot takes the pre-clear next value, so a same-edge clear loses nothing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCNT; i++) shadow_q[i] <= '0;
         snap_done_o <= 1'b0;
      end else begin
         if (snap_req_i) begin
            for (int i = 0; i < NCNT; i++) shadow_q[i] <= live_nxt[i];
         end
         snap_done_o <= snap_req_i;
      end
   end

   // ---------------- Read port ----------------
   logic [CNT_WIDTH-1:0] rd_mux;

   // Unmapped indices fall through to zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NCNT; i++) begin
         if (rd_sel_i == 4'(i)) rd_mux = shadow_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
      end else begin
         rd_valid_o <= rd_req_i;
         if (rd_req_i) rd_data_o <= rd_mux;
      end
   end

`ifdef RISCV_ICC_COMPRESSED_EN
   assign ovf_o = ovf_q;
`else
   assign ovf_o = {1'b0, ovf_q};
`endif

endmodule

// File: tb/tb_riscv_instr_class_counter.sv
// Bench for riscv_instr_class_counter: two instances (saturating and wrapping, 8-bit counters)
// driven with the same stimulus and compared every cycle against an event-level model,
// plus literal expectations for the directed scenarios.
module tb_riscv_instr_class_counter;
   localparam int W    = 8;
   localparam int MAXV = (1 << W) - 1;
`ifdef RISCV_ICC_COMPRESSED_EN
   localparam bit COMPR = 1'b1;
`else
   localparam bit COMPR = 1'b0;
`endif
   localparam int NC = COMPR ? 9 : 8;

   logic clk = 1'b0;
   logic rst, retire_valid, retire_compr, clear, snap_req, rd_req;
   logic [31:0] retire_instr;
   logic [3:0]  rd_sel;
   logic [1:0]  snap_done, rd_valid;
   logic [1:0][W-1:0] rd_data;
   logic [1:0][8:0]   ovf;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   riscv_instr_class_counter #(.CNT_WIDTH(W), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .retire_valid_i(retire_valid), .retire_instr_i(retire_instr),
      .retire_compr_i(retire_compr), .clear_i(clear), .snap_req_i(snap_req),
      .snap_done_o(snap_done[0]), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
      .rd_valid_o(rd_valid[0]), .rd_data_o(rd_data[0]), .ovf_o(ovf[0]));

   riscv_instr_class_counter #(.CNT_WIDTH(W), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .retire_valid_i(retire_valid), .retire_instr_i(retire_instr),
      .retire_compr_i(retire_compr), .clear_i(clear), .snap_req_i(snap_req),
      .snap_done_o(snap_done[1]), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
      .rd_valid_o(rd_valid[1]), .rd_data_o(rd_data[1]), .ovf_o(ovf[1]));

   // ---------------- reference model ----------------
   int          op_cls [128];        // class by opcode, before the OP/PULP_OP refinements
   int unsigned m_live   [2][9];
   int unsigned m_shadow [2][9];
   int unsigned m_rd_data[2];
   bit          m_ovf    [2][9];
   bit          m_rd_valid, m_snap_done;
   bit          p_vld, p_compr;      // retire accepted on the previous edge, counted on this one
   int          p_cls;

   function automatic int ref_class(input logic [31:0] w);
      int c;
      c = op_cls[w[6:0]];
      if (w[6:0] == 7'h33 && (w[31:25] == 7'h01 || w[31:25] == 7'h21)) c = 4;
      if (w[6:0] == 7'h5b) c = (w[14:12] inside {3'd0, 3'd1, 3'd4, 3'd5}) ? 4 : 7;
      return c;
   endfunction

   task automatic model_edge();
      int unsigned nv [2][9];
      bit          hit[2][9];
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) begin
               m_live[k][i] = 0; m_shadow[k][i] = 0; m_ovf[k][i] = 0;
            end
            m_rd_data[k] = 0;
         end
         m_rd_valid = 0; m_snap_done = 0; p_vld = 0; p_compr = 0; p_cls = 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) begin
               bit bump;
               bump = (i < NC) && p_vld && ((i < 8 && p_cls == i) || (i == 8 && p_compr));
               nv[k][i] = m_live[k][i];
               hit[k][i] = 0;
               if (bump) begin
                  if (m_live[k][i] == MAXV) begin
                     hit[k][i] = 1;
                     nv[k][i]  = (k == 0) ? MAXV : 0;
                  end else begin
                     nv[k][i] = m_live[k][i] + 1;
                  end
               end
            end
            if (rd_req) m_rd_data[k] = (int'(rd_sel) < NC) ? m_shadow[k][rd_sel] : 0;
            for (int i = 0; i < 9; i++) begin
               if (snap_req) m_shadow[k][i] = nv[k][i];
               m_live[k][i] = clear ? 0 : nv[k][i];
               m_ovf[k][i]  = clear ? 1'b0 : (m_ovf[k][i] | hit[k][i]);
            end
         end
         m_rd_valid  = rd_req;
         m_snap_done = snap_req;
         p_vld   = retire_valid;
         p_cls   = ref_class(retire_instr);
         p_compr = retire_valid && retire_compr;
      end
   endtask

   task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            logic [8:0] e_ovf;
            for (int i = 0; i < 9; i++) e_ovf[i] = m_ovf[k][i];
            check("rd_valid",  k, 64'(rd_valid[k]),  64'(m_rd_valid));
            check("rd_data",   k, 64'(rd_data[k]),   64'(m_rd_data[k]));
            check("snap_done", k, 64'(snap_done[k]), 64'(m_snap_done));
            check("ovf",       k, 64'(ovf[k]),       64'(e_ovf));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
      retire_valid = 0; retire_compr = 0; clear = 0; snap_req = 0; rd_req = 0;
   endtask

   task automatic retire(input logic [31:0] w, input logic c);
      retire_valid = 1; retire_instr = w; retire_compr = c;
      tick();
   endtask

   task automatic read_lit(input string name, input logic [3:0] sel, input int e0, input int e1);
      rd_req = 1; rd_sel = sel;
      tick();
      check(name, 0, 64'(rd_data[0]), 64'(e0));
      check(name, 1, 64'(rd_data[1]), 64'(e1));
   endtask

   logic [31:0] words [16];

   initial begin
      words = '{32'h00100093, 32'h00000063, 32'h00002083, 32'h00102023,
                32'h021080b3, 32'h300010f3, 32'h000000d3, 32'hffffffff,
                32'h0000005b, 32'h0000205b, 32'h0000000b, 32'h0000002b,
                32'h42000033, 32'h40000033, 32'h0000006f, 32'h00000043};
      for (int i = 0; i < 128; i++) op_cls[i] = 7;
      foreach (op_cls[i]) begin
         if (i == 'h33 || i == 'h13 || i == 'h37 || i == 'h17) op_cls[i] = 0;
         if (i == 'h6f || i == 'h67 || i == 'h63) op_cls[i] = 1;
         if (i == 'h03 || i == 'h0b) op_cls[i] = 2;
         if (i == 'h23 || i == 'h2b) op_cls[i] = 3;
         if (i == 'h73 || i == 'h0f) op_cls[i] = 5;
         if (i == 'h53 || i == 'h43 || i == 'h47 || i == 'h4b || i == 'h4f || i == 'h07 || i == 'h27) op_cls[i] = 6;
      end

      rst = 1; retire_valid = 0; retire_instr = 0; retire_compr = 0;
      clear = 0; snap_req = 0; rd_req = 0; rd_sel = 0;
      repeat (3) tick();
      check("reset_rd_data", 0, 64'(rd_data[0]), 64'd0);
      check("reset_ovf",     1, 64'(ovf[1]),     64'd0);
      rst = 0;
      tick();

      // T1: one retire of each class, snapshot, every class reads 1
      for (int i = 0; i < 8; i++) retire(words[i], 1'b0);
      repeat (2) tick();
      snap_req = 1; tick();
      for (int i = 0; i < 8; i++) read_lit("t1_class", 4'(i), 1, 1);

      // T2: 10 adds, snapshot right after the last count lands
      clear = 1; tick();
      for (int i = 0; i < 10; i++) retire(32'h001080b3, 1'b0);
      tick();
      snap_req = 1; tick();
      check("t2_snap_done_hi", 0, 64'(snap_done[0]), 64'd1);
      tick();
      check("t2_snap_done_lo", 0, 64'(snap_done[0]), 64'd0);
      read_lit("t2_alu", 4'd0, 10, 10);

      // T3: 256 loads overflow the 8-bit LOAD counter
      clear = 1; tick();
      for (int i = 0; i < 256; i++) retire(32'h00002083, 1'b0);
      repeat (2) tick();
      check("t3_ovf2", 0, 64'(ovf[0][2]), 64'd1);
      check("t3_ovf2", 1, 64'(ovf[1][2]), 64'd1);
      snap_req = 1; tick();
      read_lit("t3_load", 4'd2, 255, 0);

      // T4: clear on the counting edge of a load drops it; same-edge store survives
      retire(32'h00002083, 1'b0);
      clear = 1; retire(32'h00102023, 1'b0);
      repeat (2) tick();
      check("t4_ovf", 0, 64'(ovf[0]), 64'd0);
      check("t4_ovf", 1, 64'(ovf[1]), 64'd0);
      snap_req = 1; tick();
      read_lit("t4_load", 4'd2, 0, 0);
      read_lit("t4_store", 4'd3, 1, 1);

      // T5: snapshot + clear + read on one edge
      for (int i = 0; i < 3; i++) retire(32'h001080b3, 1'b0);
      repeat (2) tick();
      snap_req = 1; clear = 1;
      read_lit("t5_old_shadow", 4'd0, 0, 0);
      read_lit("t5_new_shadow", 4'd0, 3, 3);
      snap_req = 1; tick();
      read_lit("t5_live_zero", 4'd0, 0, 0);

      // T6: compressed counter and out-of-range select
      for (int i = 0; i < 5; i++) retire(32'h00100093, 1'b1);
      repeat (2) tick();
      snap_req = 1; tick();
      read_lit("t6_compr", 4'd8, COMPR ? 5 : 0, COMPR ? 5 : 0);
      read_lit("t6_sel12", 4'd12, 0, 0);
      check("t6_sel12_valid", 0, 64'(rd_valid[0]), 64'd1);

      // Randomized traffic, including one mid-run reset
      for (int n = 0; n < 4000; n++) begin
         retire_valid = ($urandom_range(3) != 0);
         retire_instr = ($urandom_range(7) == 0) ? $urandom : words[$urandom_range(15)];
         retire_compr = $urandom_range(1);
         clear        = ($urandom_range(499) == 0);
         snap_req     = ($urandom_range(7) == 0);
         rd_req       = ($urandom_range(2) == 0);
         rd_sel       = 4'($urandom_range(15));
         if (n == 2000) rst = 1;
         tick();
         rst = 0;
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
